// File: rtl/lcv_dot_acc_pkg.sv
// Shared types and saturation limits for the vector accumulator and its adder.
package lcv_dot_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Limits are built at a fixed wide width; callers keep the low `width` bits.
    localparam int LIM_W = 64;

    function automatic logic [LIM_W-1:0] acc_max(input int width);
        return (LIM_W'(1) << (width - 1)) - LIM_W'(1);
    endfunction

    function automatic logic [LIM_W-1:0] acc_min(input int width);
        return ~acc_max(width);
    endfunction

endpackage

// File: rtl/lcv_dot_acc_if.sv
// Input term stream and output result stream of the vector accumulator.
interface lcv_dot_acc_if #(
    parameter int IN_WIDTH  = 33,
    parameter int ACC_WIDTH = 48,
    parameter int CNT_WIDTH = 16
);
    // Both streams: a transfer happens on a rising clk edge where valid && ready;
    // the sender holds valid and its payload stable until that transfer.
    logic                        in_valid;
    logic                        in_ready;
    logic signed [IN_WIDTH-1:0]  in_data;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0]        out_count;
    logic                        out_sat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_sat
    );
endinterface

// File: rtl/lcv_sat_add.sv
// Signed add with overflow detect; clamps to the signed limits or wraps.
module lcv_sat_add
    import lcv_dot_acc_pkg::*;
#(
    parameter int ACC_WIDTH = 48,
    parameter bit SATURATE  = 1'b1
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic signed [ACC_WIDTH-1:0] term,
    output logic signed [ACC_WIDTH-1:0] sum,
    output logic                        ovf
);
    localparam logic [LIM_W-1:0]     MAX_WIDE = acc_max(ACC_WIDTH);
    localparam logic [LIM_W-1:0]     MIN_WIDE = acc_min(ACC_WIDTH);
    localparam logic [ACC_WIDTH-1:0] MAX_V    = MAX_WIDE[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] MIN_V    = MIN_WIDE[ACC_WIDTH-1:0];

    logic [ACC_WIDTH:0] wide;

    // One guard bit: the top bit is the true sign, so it picks the clamp direction.
    always_comb begin
        wide = {acc[ACC_WIDTH-1], acc} + {term[ACC_WIDTH-1], term};
        ovf  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
        sum  = wide[ACC_WIDTH-1:0];
        if (SATURATE && ovf) begin
            sum = wide[ACC_WIDTH] ? MIN_V : MAX_V;
        end
    end
endmodule

// File: rtl/lcv_dot_acc.sv
// Sums each in_last-delimited vector of signed terms and presents one result
// per vector with its beat count and a sticky overflow flag.
module lcv_dot_acc
    import lcv_dot_acc_pkg::*;
#(
    parameter int IN_WIDTH  = 33,
    parameter int ACC_WIDTH = 48,
    parameter int CNT_WIDTH = 16,
    parameter bit SATURATE  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    lcv_dot_acc_if.slave      bus,
    output state_t            dbg_state
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                      state;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0]        cnt_q;
    logic                        sat_q;
    logic                        out_valid_q;
    logic signed [ACC_WIDTH-1:0] out_data_q;
    logic [CNT_WIDTH-1:0]        out_count_q;
    logic                        out_sat_q;

    logic                        in_ready;
    logic                        accept;
    logic                        start;
    logic signed [ACC_WIDTH-1:0] term_ext;
    logic signed [ACC_WIDTH-1:0] add_sum;
    logic                        add_ovf;
    logic signed [ACC_WIDTH-1:0] nxt_acc;
    logic [CNT_WIDTH-1:0]        nxt_cnt;
    logic                        nxt_sat;

    assign in_ready = (state != HOLD) || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    // Any beat outside ACCUM opens a new vector, including one taken while
    // the previous result is being consumed.
    assign start    = (state != ACCUM);
    assign term_ext = {{(ACC_WIDTH-IN_WIDTH){bus.in_data[IN_WIDTH-1]}}, bus.in_data};

    lcv_sat_add #(
        .ACC_WIDTH (ACC_WIDTH),
        .SATURATE  (SATURATE)
    ) u_add (
        .acc  (acc_q),
        .term (term_ext),
        .sum  (add_sum),
        .ovf  (add_ovf)
    );

    always_comb begin
        nxt_acc = add_sum;
        nxt_cnt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        nxt_sat = sat_q | add_ovf;
        if (start) begin
            nxt_acc = term_ext;
            nxt_cnt = CNT_ONE;
            nxt_sat = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else if (accept) begin
            acc_q <= nxt_acc;
            cnt_q <= nxt_cnt;
            sat_q <= nxt_sat;
            if (bus.in_last) begin
                state       <= HOLD;
                out_valid_q <= 1'b1;
                out_data_q  <= nxt_acc;
                out_count_q <= nxt_cnt;
                out_sat_q   <= nxt_sat;
            end else begin
                state       <= ACCUM;
                out_valid_q <= 1'b0;
            end
        end else if (state == HOLD && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sat   = out_sat_q;
    assign dbg_state     = state;
endmodule
